i2c_xfer_sequencer: RTL and testbench

- Synthesizable transaction-level controller for an I2C master byte engine.
- Accepts one register-oriented transfer request at a time: device address, register address, direction and length.
- Sequences it into START / WRITE / RESTART / READ / STOP byte commands on the engine, moves write and read data bytes, and reports completion and NACK status.
- Sits between a register or CPU front end and the byte engine that drives SCL/SDA. It is the block a slave-under-test bench is stimulated through in system-level sims.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_xfer_sequencer.sv | 135 +++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C transfer sequencer: engine opcodes and sequencer states.
package i2c_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_START   = 3'd1,
    OP_WRITE   = 3'd2,
    OP_READ    = 3'd3,
    OP_RESTART = 3'd4,
    OP_STOP    = 3'd5
  } i2c_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_REG,
    S_WDATA,
    S_RESTART,
    S_DEV_R,
    S_RDATA,
    S_RD_HOLD,
    S_STOP,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE
  } seq_state_t;

  localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_xfer_sequencer.sv
// Register-oriented I2C transfer sequencer: turns one read/write request into
// START/WRITE/RESTART/READ/STOP byte commands for an I2C master byte engine.
module i2c_xfer_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rnw,
  input  logic [6:0]       req_dev_addr,
  input  logic [7:0]       req_reg_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             done_nack,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [7:0]       cmd_data,
  output logic             cmd_nack_last,
  input  logic             rsp_valid,
  input  logic             rsp_ack,
  input  logic [7:0]       rsp_data
);

  seq_state_t       state, state_d, ret_state, after_rsp;
  i2c_op_t          op_q, issue_op;
  logic [7:0]       issue_data;
  logic             issue_nl, issue_en, nack_rsp, nack_q;
  logic             rnw_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt_q;

  assign cmd_op = op_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Where the single WAIT_RSP state hands off, keyed by the state that issued the command.
  always_comb begin
    nack_rsp  = !rsp_ack && (ret_state inside {S_DEV_W, S_REG, S_WDATA, S_DEV_R});
    after_rsp = S_IDLE;
    case (ret_state)
      S_START:   after_rsp = S_DEV_W;
      S_DEV_W:   after_rsp = S_REG;
      S_REG:     after_rsp = (cnt_q == '0) ? S_STOP : (rnw_q ? S_RESTART : S_WDATA);
      S_WDATA:   after_rsp = (cnt_q == '0) ? S_STOP : S_WDATA;
      S_RESTART: after_rsp = S_DEV_R;
      S_DEV_R:   after_rsp = S_RDATA;
      S_RDATA:   after_rsp = S_RD_HOLD;
      S_STOP:    after_rsp = S_DONE;
      default:   after_rsp = S_IDLE;
    endcase
    if (nack_rsp) after_rsp = S_STOP;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (req_valid) state_d = S_START;
      S_WAIT_RSP: if (rsp_valid) state_d = after_rsp;
      S_ISSUE:    if (cmd_ready) state_d = S_WAIT_RSP;
      S_RD_HOLD:  if (rd_ready) state_d = (cnt_q == '0) ? S_STOP : S_RDATA;
      S_DONE:     state_d = S_IDLE;
      default:    if (issue_en) state_d = S_ISSUE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    cmd_valid  = (state == S_ISSUE);
    wr_ready   = (state == S_WDATA) && wr_valid;
    rd_valid   = (state == S_RD_HOLD);
    done       = (state == S_DONE);
    done_nack  = (state == S_DONE) && nack_q;
    issue_en   = 1'b1;
    issue_op   = OP_NOP;
    issue_data = 8'h00;
    issue_nl   = 1'b0;
    case (state)
      S_START:   issue_op = OP_START;
      S_DEV_W:   begin issue_op = OP_WRITE; issue_data = {dev_q, 1'b0}; end
      S_REG:     begin issue_op = OP_WRITE; issue_data = reg_q; end
      S_WDATA:   begin issue_op = OP_WRITE; issue_data = wr_data; issue_en = wr_valid; end
      S_RESTART: issue_op = OP_RESTART;
      S_DEV_R:   begin issue_op = OP_WRITE; issue_data = {dev_q, I2C_RD}; end
      S_RDATA:   begin issue_op = OP_READ; issue_nl = (cnt_q == LEN_W'(1)); end
      S_STOP:    issue_op = OP_STOP;
      default:   issue_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= OP_NOP;
      cmd_data      <= 8'h00;
      cmd_nack_last <= 1'b0;
      rd_data       <= 8'h00;
      nack_q        <= 1'b0;
      ret_state     <= S_IDLE;
    end else begin
      if (state == S_IDLE && req_valid) begin
        rnw_q  <= req_rnw;
        dev_q  <= req_dev_addr;
        reg_q  <= req_reg_addr;
        cnt_q  <= req_len;
        nack_q <= 1'b0;
      end
      if (issue_en) begin
        ret_state     <= state;
        op_q          <= issue_op;
        cmd_data      <= issue_data;
        cmd_nack_last <= issue_nl;
        // WDATA/RDATA are only entered with a nonzero count, so this never wraps.
        if (state == S_WDATA || state == S_RDATA) cnt_q <= cnt_q - LEN_W'(1);
      end
      if (state == S_WAIT_RSP && rsp_valid) begin
        if (nack_rsp) nack_q <= 1'b1;
        if (ret_state == S_RDATA) rd_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Bench for i2c_xfer_sequencer: table of transfers checked against a command
// scoreboard driven by a behavioural byte engine, plus a mid-transfer reset sequence.
module tb_i2c_xfer_sequencer;
  import i2c_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       nl;
  } cmd_t;

  typedef struct {
    logic        rnw;
    logic [6:0]  dev;
    logic [7:0]  regaddr;
    int          len;
    logic [23:0] bytes;
    int          nack_at;
    int          stall;
    int          hold;
    logic        exp_nack;
  } vec_t;

  logic       clk, rst;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done, done_nack;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack_last;
  logic       rsp_valid, rsp_ack;
  logic [7:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  cmd_t       sbq[$];
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] eng_rdq[$];

  int eng_cnt = 0;
  int wr_pulses = 0;
  int nack_abs = -1;
  int norsp_abs = -1;
  int stall_cyc = 0;
  int rd_hold = 0;

  vec_t vecs[9];

  i2c_xfer_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .done_nack(done_nack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack_last(cmd_nack_last),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    if (i < 3) return v.bytes[i*8 +: 8];
    return i[7:0] ^ 8'h5A;
  endfunction

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] d, input logic nl);
    cmd_t c;
    c.op = op; c.data = d; c.nl = nl;
    sbq.push_back(c);
  endtask

  // Reference model: expected command stream, write bytes offered, read bytes expected.
  task automatic build(input vec_t v, output int exp_wr);
    int idx;
    bit nk;
    idx = 0; nk = 0; exp_wr = 0;
    push_cmd(OP_START, 8'h00, 1'b0); idx++;
    push_cmd(OP_WRITE, {v.dev, 1'b0}, 1'b0); nk = (idx == v.nack_at); idx++;
    if (!nk) begin
      push_cmd(OP_WRITE, v.regaddr, 1'b0); nk = (idx == v.nack_at); idx++;
    end
    if (!nk && v.len > 0) begin
      if (v.rnw) begin
        push_cmd(OP_RESTART, 8'h00, 1'b0); idx++;
        push_cmd(OP_WRITE, {v.dev, 1'b1}, 1'b0); nk = (idx == v.nack_at); idx++;
        for (int i = 0; i < v.len && !nk; i++) begin
          push_cmd(OP_READ, 8'h00, i == v.len - 1);
          rq.push_back(vbyte(v, i));
          eng_rdq.push_back(vbyte(v, i));
          idx++;
        end
      end else begin
        for (int i = 0; i < v.len && !nk; i++) begin
          push_cmd(OP_WRITE, vbyte(v, i), 1'b0);
          exp_wr++;
          nk = (idx == v.nack_at); idx++;
        end
      end
    end
    if (!v.rnw)
      for (int i = 0; i < v.len; i++) wq.push_back(vbyte(v, i));
    push_cmd(OP_STOP, 8'h00, 1'b0);
  endtask

  // Byte engine: accepts commands after an optional stall, checks them against the scoreboard, responds.
  always begin
    logic [11:0] snap;
    cmd_t        exp;
    int          myidx;
    @(negedge clk);
    if (cmd_valid && !rst) begin
      snap = {cmd_op, cmd_data, cmd_nack_last};
      for (int s = 0; s < stall_cyc; s++) begin
        @(negedge clk);
        chk("cmd_hold_valid", {31'd0, cmd_valid}, 32'd1);
        chk("cmd_hold_fields", {20'd0, cmd_op, cmd_data, cmd_nack_last}, {20'd0, snap});
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      myidx = eng_cnt;
      eng_cnt++;
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_unexpected: got op %0d, expected no command", snap[11:9]);
      end else begin
        exp = sbq.pop_front();
        chk("cmd_op", {29'd0, snap[11:9]}, {29'd0, exp.op});
        if (exp.op == OP_WRITE) chk("cmd_data", {24'd0, snap[8:1]}, {24'd0, exp.data});
        if (exp.op == OP_READ)  chk("cmd_nack_last", {31'd0, snap[0]}, {31'd0, exp.nl});
      end
      if (myidx != norsp_abs) begin
        rsp_valid = 1'b1;
        rsp_ack   = (myidx != nack_abs);
        rsp_data  = (snap[11:9] == OP_READ && eng_rdq.size() > 0) ? eng_rdq.pop_front() : 8'h00;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;
      end
    end
  end

  // Write-data source: offers the head of wq, counts wr_ready pulses.
  always begin
    logic take;
    @(negedge clk);
    take = wr_ready;
    @(posedge clk);
    #1;
    if (take) begin
      wr_pulses++;
      if (wq.size() > 0) void'(wq.pop_front());
    end
    wr_valid = (wq.size() > 0);
    wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
  end

  // Read-data sink: holds off rd_ready for rd_hold cycles, then checks against rq.
  always begin
    logic [7:0] rsnap;
    logic [7:0] rexp;
    @(negedge clk);
    if (rd_valid) begin
      rsnap = rd_data;
      for (int h = 0; h < rd_hold; h++) begin
        @(negedge clk);
        chk("rd_hold_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd_hold_data", {24'd0, rd_data}, {24'd0, rsnap});
        chk("rd_hold_no_cmd", {31'd0, cmd_valid}, 32'd0);
      end
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read byte", rd_data);
      end else begin
        rexp = rq.pop_front();
        chk("rd_data", {24'd0, rd_data}, {24'd0, rexp});
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({tag, "_wr_ready"},  {31'd0, wr_ready}, 32'd0);
    chk({tag, "_rd_valid"},  {31'd0, rd_valid}, 32'd0);
    chk({tag, "_done"},      {31'd0, done}, 32'd0);
    chk({tag, "_done_nack"}, {31'd0, done_nack}, 32'd0);
    chk({tag, "_cmd_op"},    {29'd0, cmd_op}, {29'd0, OP_NOP});
    chk({tag, "_cmd_data"},  {24'd0, cmd_data}, 32'd0);
    chk({tag, "_rd_data"},   {24'd0, rd_data}, 32'd0);
  endtask

  task automatic issue_req(input vec_t v);
    @(negedge clk);
    req_rnw      = v.rnw;
    req_dev_addr = v.dev;
    req_reg_addr = v.regaddr;
    req_len      = v.len[7:0];
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid    = 1'b0;
    chk("req_ready_drop", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int  exp_wr, p0, c;
    bit  seen;
    nack_abs  = (v.nack_at < 0) ? -1 : eng_cnt + v.nack_at;
    norsp_abs = -1;
    stall_cyc = v.stall;
    rd_hold   = v.hold;
    build(v, exp_wr);
    repeat (2) @(negedge clk);
    p0 = wr_pulses;
    issue_req(v);
    seen = 0;
    for (c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_nack && !done) chk("done_nack_without_done", 32'd1, 32'd0);
      if (done) begin seen = 1; break; end
    end
    chk($sformatf("v%0d_done_seen", k), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d_done_nack", k), {31'd0, done_nack}, {31'd0, v.exp_nack});
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", k), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_req_ready_back", k), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d_cmds_left", k), sbq.size(), 32'd0);
    chk($sformatf("v%0d_rd_left", k), rq.size(), 32'd0);
    chk($sformatf("v%0d_wr_pulses", k), wr_pulses - p0, exp_wr);
    sbq.delete();
    rq.delete();
    wq.delete();
    eng_rdq.delete();
  endtask

  initial begin
    int base, c;
    int dummy;
    rst = 1'b1;
    req_valid = 0; req_rnw = 0; req_dev_addr = '0; req_reg_addr = '0; req_len = '0;
    rd_ready = 0; cmd_ready = 0; rsp_valid = 0; rsp_ack = 0; rsp_data = '0;
    wr_valid = 0; wr_data = '0;

    //          rnw   dev    reg    len  bytes(b2,b1,b0)  nack stall hold exp_nack
    vecs[0] = '{1'b0, 7'h50, 8'h10, 2,   24'h0055AA,      -1,  0,    0,   1'b0};
    vecs[1] = '{1'b1, 7'h50, 8'h20, 3,   24'h332211,      -1,  0,    0,   1'b0};
    vecs[2] = '{1'b0, 7'h3C, 8'h44, 2,   24'h000201,       1,  0,    0,   1'b1};
    vecs[3] = '{1'b1, 7'h2A, 8'h05, 2,   24'h003CC3,      -1,  5,    20,  1'b0};
    vecs[4] = '{1'b1, 7'h50, 8'h07, 0,   24'h000000,      -1,  0,    0,   1'b0};
    vecs[5] = '{1'b0, 7'h11, 8'h22, 1,   24'h00009E,       3,  0,    0,   1'b1};
    vecs[6] = '{1'b1, 7'h12, 8'h34, 2,   24'h00BEEF,       4,  0,    0,   1'b1};
    vecs[7] = '{1'b0, 7'h7F, 8'hFF, 0,   24'h000000,      -1,  0,    0,   1'b0};
    vecs[8] = '{1'b0, 7'h01, 8'h00, 255, 24'h0F5AA5,      -1,  0,    0,   1'b0};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

    // Reset while waiting for the REG response, then a clean transfer must still work.
    nack_abs  = -1;
    stall_cyc = 0;
    rd_hold   = 0;
    base      = eng_cnt;
    norsp_abs = base + 2;
    build(vecs[0], dummy);
    repeat (2) @(negedge clk);
    issue_req(vecs[0]);
    for (c = 0; c < 200 && eng_cnt < base + 3; c++) @(negedge clk);
    chk("mid_reg_accepted", {31'd0, eng_cnt >= base + 3}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    sbq.delete();
    wq.delete();
    norsp_abs = -1;
    run_vec(vecs[0], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
